// File: rtl/dm_cache_pkg.sv
`default_nettype none
// ============================================================================
// dm_cache_pkg : geometry, FSM states and record types of the direct-mapped cache
// Rev 1.0
// ============================================================================
package dm_cache_pkg;

   localparam int DC_ADDR_W  = 32;
   localparam int DC_WORD_W  = 32;
   localparam int DC_LINE_W  = 128;
   localparam int DC_INDEX_W = 10;
   localparam int DC_OFFS_W  = 4;
   localparam int DC_TAG_W   = DC_ADDR_W - DC_INDEX_W - DC_OFFS_W;
   localparam int DC_LINES   = 1 << DC_INDEX_W;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      COMPARE    = 2'd1,
      WRITE_BACK = 2'd2,
      ALLOCATE   = 2'd3
   } state_e;

   typedef struct packed {
      logic                 rw;
      logic [DC_ADDR_W-1:0] addr;
      logic [DC_WORD_W-1:0] data;
   } cpu_req_t;

   typedef struct packed {
      logic                 rw;
      logic [DC_ADDR_W-1:0] addr;
      logic [DC_LINE_W-1:0] data;
   } mem_req_t;

   typedef struct packed {
      logic                valid;
      logic                dirty;
      logic [DC_TAG_W-1:0] tag;
   } tag_entry_t;

   function automatic logic [DC_ADDR_W-1:0] line_addr(input logic [DC_TAG_W-1:0]   tag,
                                                      input logic [DC_INDEX_W-1:0] index);
      return {tag, index, {DC_OFFS_W{1'b0}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_tag.sv
`default_nettype none
// ============================================================================
// dm_cache_tag : per-line tag/valid/dirty store; combinational read, sync write
// Rev 1.0
// ============================================================================
module dm_cache_tag
   import dm_cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DC_INDEX_W-1:0] index,
   input  logic                  we,
   input  tag_entry_t            wr_entry,
   output tag_entry_t            rd_entry
);

   logic [DC_TAG_W-1:0] tag_mem [DC_LINES];
   logic [DC_LINES-1:0] valid_q, valid_d;
   logic [DC_LINES-1:0] dirty_q, dirty_d;

   // Tags need no reset: a line is only trusted when its valid flop is set.
   always_ff @(posedge clk) begin
      if (we) tag_mem[index] <= wr_entry.tag;
   end

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (we) begin
         valid_d[index] = wr_entry.valid;
         dirty_d[index] = wr_entry.dirty;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   assign rd_entry = '{valid: valid_q[index], dirty: dirty_q[index], tag: tag_mem[index]};

endmodule
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// dm_cache_ctrl : write-back, write-allocate direct-mapped data cache controller
// Option: define DM_CACHE_STATS_EN to add hit_cnt/miss_cnt outputs.  Rev 1.0
// ============================================================================
module dm_cache_ctrl
   import dm_cache_pkg::*;
#(
   parameter int ADDR_W  = DC_ADDR_W,
   parameter int WORD_W  = DC_WORD_W,
   parameter int LINE_W  = DC_LINE_W,
   parameter int INDEX_W = DC_INDEX_W,
   parameter int TAG_W   = DC_TAG_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_req_valid,
   input  logic               cpu_req_rw,
   input  logic [ADDR_W-1:0]  cpu_req_addr,
   input  logic [WORD_W-1:0]  cpu_req_data,
   output logic               cpu_res_ready,
   output logic [WORD_W-1:0]  cpu_res_data,
   output logic [INDEX_W-1:0] data_req_index,
   output logic               data_req_we,
   output logic [LINE_W-1:0]  data_write,
   input  logic [LINE_W-1:0]  data_read,
   output logic               mem_req_valid,
   output logic               mem_req_rw,
   output logic [ADDR_W-1:0]  mem_req_addr,
   output logic [LINE_W-1:0]  mem_req_data,
   input  logic               mem_ready,
   input  logic [LINE_W-1:0]  mem_data
`ifdef DM_CACHE_STATS_EN
   ,
   output logic [31:0]        hit_cnt,
   output logic [31:0]        miss_cnt
`endif
);

   if (TAG_W != ADDR_W - INDEX_W - 4) begin : g_tag_w_check
      $error("dm_cache_ctrl: TAG_W must equal ADDR_W-INDEX_W-4");
   end

   state_e                 state_q, state_d;
   cpu_req_t               req_q, req_d;
   mem_req_t               mem_req_q, mem_req_d;
   logic                   mem_req_valid_q, mem_req_valid_d;
   logic                   cpu_res_ready_q, cpu_res_ready_d;
   logic [WORD_W-1:0]      cpu_res_data_q, cpu_res_data_d;

   logic [INDEX_W-1:0]     req_index;
   logic [TAG_W-1:0]       req_tag;
   logic [1:0]             word_sel;
   logic                   hit;
   logic                   tag_we;
   tag_entry_t             tag_rd, tag_wr;
   logic [LINE_W-1:0]      line_merged;
   logic                   unused_addr_bits;

   assign req_index = req_q.addr[13:4];
   assign req_tag   = req_q.addr[31:14];
   assign word_sel  = req_q.addr[3:2];
   assign hit       = tag_rd.valid && (tag_rd.tag == req_tag);
   assign unused_addr_bits = ^{cpu_req_addr[1:0], req_q.addr[1:0]};

   dm_cache_tag u_tag (
      .clk      (clk),
      .rst      (rst),
      .index    (req_index),
      .we       (tag_we),
      .wr_entry (tag_wr),
      .rd_entry (tag_rd)
   );

   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      mem_req_d       = mem_req_q;
      mem_req_valid_d = mem_req_valid_q;
      cpu_res_ready_d = 1'b0;
      cpu_res_data_d  = cpu_res_data_q;
      data_req_we     = 1'b0;
      data_write      = data_read;
      tag_we          = 1'b0;
      tag_wr          = tag_rd;
      line_merged     = data_read;
      line_merged[word_sel*WORD_W +: WORD_W] = req_q.data;

      unique case (state_q)
         IDLE: begin
            // The CPU still holds the finished request during the response cycle.
            if (cpu_req_valid && !cpu_res_ready_q) begin
               req_d   = '{rw: cpu_req_rw, addr: {cpu_req_addr[ADDR_W-1:2], 2'b00},
                           data: cpu_req_data};
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (hit) begin
               cpu_res_ready_d = 1'b1;
               state_d         = IDLE;
               if (req_q.rw) begin
                  data_req_we  = 1'b1;
                  data_write   = line_merged;
                  tag_we       = 1'b1;
                  tag_wr.dirty = 1'b1;
               end else begin
                  cpu_res_data_d = data_read[word_sel*WORD_W +: WORD_W];
               end
            end else begin
               mem_req_valid_d = 1'b1;
               if (tag_rd.valid && tag_rd.dirty) begin
                  mem_req_d = '{rw: 1'b1, addr: line_addr(tag_rd.tag, req_index), data: data_read};
                  state_d   = WRITE_BACK;
               end else begin
                  mem_req_d.rw   = 1'b0;
                  mem_req_d.addr = line_addr(req_tag, req_index);
                  state_d        = ALLOCATE;
               end
            end
         end
         WRITE_BACK: begin
            if (mem_ready) begin
               mem_req_d.rw   = 1'b0;
               mem_req_d.addr = line_addr(req_tag, req_index);
               state_d        = ALLOCATE;
            end
         end
         ALLOCATE: begin
            // The retry through COMPARE then completes as an ordinary hit.
            if (mem_ready) begin
               data_req_we     = 1'b1;
               data_write      = mem_data;
               tag_we          = 1'b1;
               tag_wr          = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
               mem_req_valid_d = 1'b0;
               state_d         = COMPARE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         req_q           <= '0;
         mem_req_q       <= '0;
         mem_req_valid_q <= 1'b0;
         cpu_res_ready_q <= 1'b0;
         cpu_res_data_q  <= '0;
      end else begin
         state_q         <= state_d;
         req_q           <= req_d;
         mem_req_q       <= mem_req_d;
         mem_req_valid_q <= mem_req_valid_d;
         cpu_res_ready_q <= cpu_res_ready_d;
         cpu_res_data_q  <= cpu_res_data_d;
      end
   end

   assign cpu_res_ready  = cpu_res_ready_q;
   assign cpu_res_data   = cpu_res_data_q;
   assign data_req_index = req_index;
   assign mem_req_valid  = mem_req_valid_q;
   assign mem_req_rw     = mem_req_q.rw;
   assign mem_req_addr   = mem_req_q.addr;
   assign mem_req_data   = mem_req_q.data;

`ifdef DM_CACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == COMPARE) begin
         if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
         else     miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire
